// File: rtl/word_arb_pkg.sv
// Shared types and constants for the byte-stream word arbiter and its helpers.
package word_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF        = 4;
    localparam int BYTES_PER_WORD_DEF = 4;
    localparam int CNT_W              = $clog2(BYTES_PER_WORD_DEF);
    localparam int ID_W               = $clog2(NUM_REQ_DEF);
    localparam logic [7:0] PAD_BYTE   = 8'h00;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int safe_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: first valid requester at or after rr_ptr,
// wrapping around. Shared by the arbiters of the mux front end.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_valid
);

    function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] p, input int k);
        return ID_W'((int'(p) + k) % N);
    endfunction

    // Scan from the farthest position back toward rr_ptr so the nearest valid one wins.
    always_comb begin
        winner    = '0;
        any_valid = |req_valid;
        for (int k = N - 1; k >= 0; k--) begin
            winner = req_valid[rot(rr_ptr, k)] ? rot(rr_ptr, k) : winner;
        end
    end

endmodule

// File: rtl/word_arbiter_8_32.sv
// Round-robin byte arbiter feeding the 8->32 mux; one requester owns a full word per turn.
// Optional stall padding is enabled with the macro WORD_TIMEOUT_EN.
module word_arbiter_8_32
    import word_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYC    = 8
) (
    input  logic                         clk_4f,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         word_start,
    output logic                         word_end,
    output logic                         timeout_out
);

    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = safe_w(BYTES_PER_WORD);
    localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [GID_W-1:0]  LAST_ID  = GID_W'(NUM_REQ - 1);

    arb_state_e          state_r;
    arb_state_e          state_s;
    logic [GID_W-1:0]    rr_ptr_r;
    logic [GID_W-1:0]    rr_ptr_s;
    logic [GID_W-1:0]    winner_s;
    logic [GID_W-1:0]    src_s;
    logic [BCNT_W-1:0]   byte_cnt_r;
    logic [BCNT_W-1:0]   byte_cnt_s;
    logic [BCNT_W-1:0]   cur_cnt_s;
    logic                any_valid_s;
    logic                emit_s;
    logic                pad_s;
    logic                last_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic [DATA_W-1:0]   data_s;
`ifdef WORD_TIMEOUT_EN
    localparam int STALL_W = safe_w(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYC - 1);
    logic [STALL_W-1:0]  stall_r;
    logic [STALL_W-1:0]  stall_s;
`endif

    rr_picker #(
        .N    (NUM_REQ),
        .ID_W (GID_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    assign req_ready = reset ? {NUM_REQ{1'b0}} : ready_s;

    // Grant selection, byte emission and next-state decision for the current cycle.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        byte_cnt_s = byte_cnt_r;
        cur_cnt_s  = byte_cnt_r;
        ready_s    = '0;
        emit_s     = 1'b0;
        pad_s      = 1'b0;
        src_s      = grant_id;
`ifdef WORD_TIMEOUT_EN
        stall_s    = stall_r;
`endif
        case (state_r)
            IDLE: begin
                cur_cnt_s = '0;
                if (any_valid_s) begin
                    ready_s[winner_s] = 1'b1;
                    emit_s            = 1'b1;
                    src_s             = winner_s;
                end else begin
                    emit_s = 1'b0;
                end
            end
            BURST: begin
                ready_s[grant_id] = 1'b1;
                emit_s            = req_valid[grant_id];
            end
`ifdef WORD_TIMEOUT_EN
            PAD: begin
                emit_s = 1'b1;
                pad_s  = 1'b1;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase

        last_s = (cur_cnt_s == LAST_CNT);
        data_s = pad_s ? DATA_W'(PAD_BYTE) : req_data[src_s*DATA_W +: DATA_W];

        if (emit_s) begin
`ifdef WORD_TIMEOUT_EN
            stall_s = '0;
`endif
            if (last_s) begin
                state_s    = IDLE;
                byte_cnt_s = '0;
                rr_ptr_s   = (src_s == LAST_ID) ? GID_W'(0) : src_s + GID_W'(1);
            end else begin
                state_s    = pad_s ? PAD : BURST;
                byte_cnt_s = cur_cnt_s + BCNT_W'(1);
            end
        end else begin
`ifdef WORD_TIMEOUT_EN
            // A granted requester that keeps stalling forfeits the rest of its word.
            if (state_r == BURST) begin
                if (stall_r == STALL_MAX) begin
                    state_s = PAD;
                    stall_s = '0;
                end else begin
                    stall_s = stall_r + STALL_W'(1);
                end
            end else begin
                stall_s = '0;
            end
`else
            state_s = state_r;
`endif
        end
    end

    // State and registered output stage; data_out and grant_id hold when nothing is emitted.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            byte_cnt_r  <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            grant_id    <= '0;
            word_start  <= 1'b0;
            word_end    <= 1'b0;
            timeout_out <= 1'b0;
`ifdef WORD_TIMEOUT_EN
            stall_r     <= '0;
`endif
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            byte_cnt_r  <= byte_cnt_s;
            data_out    <= emit_s ? data_s : data_out;
            valid_out   <= emit_s;
            grant_id    <= emit_s ? src_s : grant_id;
            word_start  <= emit_s && (cur_cnt_s == BCNT_W'(0));
            word_end    <= emit_s && last_s;
            timeout_out <= pad_s;
`ifdef WORD_TIMEOUT_EN
            stall_r     <= stall_s;
`endif
        end
    end

endmodule

// File: tb/tb_word_arbiter_8_32.sv
// Scoreboard bench for word_arbiter_8_32: directed scenarios plus randomized traffic
// against a word-level round-robin reference model.
module tb_word_arbiter_8_32;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int BPW     = 4;
`ifdef WORD_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 8;
`endif

    typedef struct {
        logic [7:0] data;
        int         id;
        bit         start;
        bit         last;
        bit         tmo;
    } item_t;

    logic                      clk_4f = 1'b0;
    logic                      reset  = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         data_out;
    logic                      valid_out;
    logic [1:0]                grant_id;
    logic                      word_start;
    logic                      word_end;
    logic                      timeout_out;

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t exp_q[$];

    logic [NUM_REQ-1:0] lane_v;
    logic [7:0]         lane_d [NUM_REQ];

    // reference model: owner of the current word (-1 = none), bytes taken, rotation pointer
    int m_owner = -1;
    int m_taken = 0;
    int m_ptr   = 0;
`ifdef WORD_TIMEOUT_EN
    int m_stall = 0;
    bit m_pad   = 1'b0;
`endif

    word_arbiter_8_32 #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .BYTES_PER_WORD (BPW),
        .TIMEOUT_CYC    (8)
    ) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .grant_id    (grant_id),
        .word_start  (word_start),
        .word_end    (word_end),
        .timeout_out (timeout_out)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive lanes, predict the accept, check req_ready, queue the byte.
    task automatic step(output int acc);
        item_t              it;
        logic [NUM_REQ-1:0] exp_rdy;
        bit                 emit;
        @(negedge clk_4f);
        reset     = 1'b0;
        req_valid = lane_v;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = lane_d[i];
        acc     = -1;
        exp_rdy = '0;
        emit    = 1'b0;
        it.data = 8'h00;
        it.id   = 0;
        it.tmo  = 1'b0;
`ifdef WORD_TIMEOUT_EN
        if (m_pad) begin
            emit  = 1'b1;
            it.id = m_owner;
            it.tmo = 1'b1;
        end else
`endif
        if (m_owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (acc < 0 && lane_v[(m_ptr + k) % NUM_REQ]) acc = (m_ptr + k) % NUM_REQ;
            end
            if (acc >= 0) exp_rdy[acc] = 1'b1;
        end else begin
            exp_rdy[m_owner] = 1'b1;
            if (lane_v[m_owner]) acc = m_owner;
        end
        if (acc >= 0) begin
            emit    = 1'b1;
            it.data = lane_d[acc];
            it.id   = acc;
        end
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (emit) begin
            it.start = (m_taken == 0);
            it.last  = (m_taken + 1 == BPW);
            exp_q.push_back(it);
            if (it.last) begin
                m_ptr   = (it.id + 1) % NUM_REQ;
                m_owner = -1;
                m_taken = 0;
`ifdef WORD_TIMEOUT_EN
                m_pad   = 1'b0;
`endif
            end else begin
                m_owner = it.id;
                m_taken++;
            end
`ifdef WORD_TIMEOUT_EN
            m_stall = 0;
        end else if (m_owner >= 0) begin
            m_stall++;
            if (m_stall == TIMEOUT_CYC) begin
                m_pad   = 1'b1;
                m_stall = 0;
            end
`endif
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_4f);
            reset     = 1'b1;
            req_valid = '1;
            #1;
            chk("rst_ready", 64'(req_ready), 64'd0);
        end
        m_owner = -1;
        m_taken = 0;
        m_ptr   = 0;
`ifdef WORD_TIMEOUT_EN
        m_stall = 0;
        m_pad   = 1'b0;
`endif
    endtask

    // Monitor: every edge either presents exactly the queued byte or an idle, holding output.
    initial begin : monitor
        item_t      it;
        logic       rst_at_edge;
        logic [7:0] hold_d  = 8'h00;
        int         hold_id = 0;
        forever begin
            @(posedge clk_4f);
            rst_at_edge = reset;
            #1;
            if (rst_at_edge) begin
                chk("rst_outputs", 64'({data_out, valid_out, grant_id, word_start, word_end, timeout_out}), 64'd0);
                hold_d  = 8'h00;
                hold_id = 0;
            end else if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk("valid_out", 64'(valid_out), 64'd1);
                chk("data_out", 64'(data_out), 64'(it.data));
                chk("grant_id", 64'(grant_id), 64'(it.id));
                chk("word_start", 64'(word_start), 64'(it.start));
                chk("word_end", 64'(word_end), 64'(it.last));
                chk("timeout_out", 64'(timeout_out), 64'(it.tmo));
                hold_d  = it.data;
                hold_id = it.id;
            end else begin
                chk("idle_valid", 64'({valid_out, word_start, word_end, timeout_out}), 64'd0);
                chk("hold_data", 64'(data_out), 64'(hold_d));
                chk("hold_grant", 64'(grant_id), 64'(hold_id));
            end
        end
    end

    initial begin : driver
        int         acc;
        int         n3;
        logic [7:0] seq1 [7];
        lane_v = '0;
        for (int i = 0; i < NUM_REQ; i++) lane_d[i] = 8'(8'h10 * (i + 1));

        do_reset(3);

        // requester 2 alone: AA BB CC DD
        lane_v = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            lane_d[2] = 8'(8'hAA + 8'h11 * b);
            step(acc);
        end
        lane_v = '0;
        step(acc);

        // all requesters continuously valid for five words
        lane_v = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step(acc);
            if (acc >= 0) lane_d[acc] = lane_d[acc] + 8'd1;
        end
        lane_v = '0;
        step(acc);

        // requester 1 stalls mid-word while requester 3 waits
        seq1 = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44};
        n3 = 0;
        for (int c = 0; c < 11; c++) begin
            lane_v[1] = (c < 7) && (c < 2 || c > 4);
            lane_d[1] = (c < 7) ? seq1[c] : 8'h00;
            lane_v[3] = 1'b1;
            lane_d[3] = 8'(8'h30 + n3);
            step(acc);
            if (acc == 3) n3++;
        end
        lane_v = '0;
        step(acc);

        // reset after two bytes of a word from requester 2
        lane_v = 4'b0100;
        step(acc);
        lane_d[2] = 8'h5C;
        step(acc);
        do_reset(2);
        lane_v = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            step(acc);
            if (acc >= 0) lane_d[acc] = lane_d[acc] + 8'd3;
        end

`ifdef WORD_TIMEOUT_EN
        // requester 0 sends one byte then stalls long enough to be padded out
        do_reset(1);
        lane_v = 4'b0001;
        lane_d[0] = 8'h5A;
        step(acc);
        lane_v = 4'b1110;
        for (int c = 0; c < 16; c++) begin
            step(acc);
            if (acc >= 0) lane_d[acc] = lane_d[acc] + 8'd1;
        end
`endif

        // randomized traffic; a pending byte stays valid and stable until taken
        lane_v = '0;
        acc = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(lane_v[i] && acc != i)) begin
                    lane_v[i] = ($urandom_range(0, 99) < 65);
                    lane_d[i] = 8'($urandom);
                end
            end
            step(acc);
        end

        lane_v = '0;
        step(acc);
        step(acc);
        @(negedge clk_4f);
        @(negedge clk_4f);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
